queue_fifo: RTL and testbench
=============================

Name: queue_fifo

Overview:
- Circular-buffer FIFO queue. It is the first-in-first-out counterpart of the LIFO stack used in the same datapath.
- Elements are written at the tail and read from the head, so a sequence of moves or values is replayed in the order it was recorded rather than reversed.
- Built as a small controller FSM (occupancy state) plus a datapath (head/tail pointers, occupancy counter, storage array).
- Sits beside the stack: the solver pushes entries in, and the consumer pops them out in arrival order.

Parameters:
- WIDTH, 2, data width of each entry in bits.
- LENGTH, 8, pointer width in bits; depth is 2**LENGTH entries.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  enqueue request, sampled at the rising edge.
- pop  input  1  dequeue request, sampled at the rising edge.
- init  input  1  synchronous clear of queue contents (pointers and count); lower priority than rst.
- data_in  input  WIDTH  entry to enqueue when push is accepted.
- data_out  output  WIDTH  last dequeued entry (registered).
- valid_out  output  1  one-cycle pulse: data_out was updated this cycle.
- count  output  LENGTH+1  current occupancy, 0..2**LENGTH.
- full  output  1  count == 2**LENGTH.
- empty  output  1  count == 0.
- ovf_err  output  1  sticky rejected-push flag (see Optional Feature).
- unf_err  output  1  sticky rejected-pop flag (see Optional Feature).

Behaviour:
- Reset values (rst=1 at an edge):
  - head=0, tail=0, count=0.
  - FSM=S_EMPTY.
  - data_out=0, valid_out=0, ovf_err=0, unf_err=0.
  - Storage array is not cleared.
- init=1 with rst=0: same as reset, except data_out holds its value. push and pop are ignored in that cycle.
- FSM states: S_EMPTY, S_PART, S_FULL.
  - empty=1 only in S_EMPTY.
  - full=1 only in S_FULL.
  - Both flags are decoded from state and are registered, not combinational from inputs.
- Acceptance is evaluated on the pre-edge state:
  - push_ok = push & ~full
  - pop_ok = pop & ~empty
- push_ok: mem[tail] <= data_in; tail <= tail+1, wrapping modulo 2**LENGTH.
- pop_ok:
  - data_out <= mem[head]; head <= head+1, wrapping.
  - valid_out=1 in the following cycle only.
  - Read latency is 1 clock from the sampling edge.
- count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged if both or neither.
- Simultaneous push and pop in S_PART: both are performed, count is unchanged, and the state stays S_PART.
- Simultaneous push and pop in S_EMPTY: the push is accepted, the pop is rejected, and the next state is S_PART. The new entry is not bypassed to data_out.
- Simultaneous push and pop in S_FULL: the pop is accepted, the push is rejected, and the next state is S_PART.
- Transitions:
  - S_EMPTY -> S_PART on push_ok.
  - S_PART -> S_FULL when push_ok & ~pop_ok & count == 2**LENGTH-1.
  - S_PART -> S_EMPTY when pop_ok & ~push_ok & count == 1.
  - S_FULL -> S_PART on pop_ok.
  - Otherwise the state holds.
- Rejected operations leave pointers, count, data_out and storage unchanged. valid_out stays 0.
- Invariant: count == (tail - head) mod 2**LENGTH, except in S_FULL where head == tail and count == 2**LENGTH.
- rst or init asserted mid-stream discards all stored entries in the same edge. A pop requested in that cycle produces no valid_out pulse.

Optional Feature:
- Macro: QUEUE_OVF_FLAG_EN.
- Defined:
  - ovf_err is set on any edge with push & full.
  - unf_err is set on any edge with pop & empty.
  - Both are sticky until rst or init.
- Not defined: ovf_err and unf_err are tied to 0. The port list is unchanged.

Test Plan (WIDTH=2, LENGTH=2, depth 4):
- Reset then idle -> count=0, empty=1, full=0, data_out=0, valid_out=0.
- Push 3,1,2,0 on consecutive cycles -> count=4, full=1. Then pop 4 times -> data_out 3,1,2,0 each one cycle after its pop with valid_out=1, ending empty=1.
- Fill to 4 entries, push 2 more with data_in=1 -> count stays 4, contents unchanged. Pop 4 -> original order. With QUEUE_OVF_FLAG_EN, ovf_err=1 until init.
- Wrap-around: push 2, pop 2, then push 4 values 1,2,3,0 -> full=1, pops return 1,2,3,0, so the pointers wrap correctly.
- Hold push and pop together for 6 cycles from count=2 -> count stays 2, FIFO order preserved. From empty: count becomes 1, no valid_out. From full: count becomes 3.
- Pop on empty -> no valid_out, data_out held, unf_err=1 (macro on). Assert init with 3 entries stored -> count=0, empty=1, data_out unchanged.

Source files
------------

// File: rtl/queue_fifo.sv
// Circular-buffer FIFO: occupancy FSM plus head/tail/count datapath over a 2**LENGTH entry array.
// Optional sticky overflow/underflow flags when QUEUE_OVF_FLAG_EN is defined.
module queue_fifo #(
   parameter int unsigned WIDTH  = 2,
   parameter int unsigned LENGTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              init,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              valid_out,
   output logic [LENGTH:0]   count,
   output logic              full,
   output logic              empty,
   output logic              ovf_err,
   output logic              unf_err
);

   localparam int unsigned    DEPTH_I   = 2 ** LENGTH;
   localparam logic [LENGTH:0] DEPTH    = (LENGTH+1)'(DEPTH_I);
   localparam logic [LENGTH:0] ONE      = (LENGTH+1)'(1);
   localparam logic [LENGTH:0] ALMOST   = DEPTH - ONE;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_PART  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    mem [DEPTH_I];
   logic [LENGTH-1:0]   head, tail;
   logic                push_ok, pop_ok;
   logic                clear;

   assign clear   = rst | init;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // State register
   always_ff @(posedge clk) begin
      if (clear) state <= S_EMPTY;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY: if (push_ok) state_nxt = S_PART;
         S_PART: begin
            if (push_ok && !pop_ok && count == ALMOST)   state_nxt = S_FULL;
            else if (pop_ok && !push_ok && count == ONE) state_nxt = S_EMPTY;
         end
         S_FULL:  if (pop_ok) state_nxt = S_PART;
         default: state_nxt = S_EMPTY;
      endcase
   end

   // Flags decoded from the registered state
   always_comb begin
      empty = (state == S_EMPTY);
      full  = (state == S_FULL);
   end

   // Storage is deliberately left uninitialised on reset
   always_ff @(posedge clk) begin
      if (!clear && push_ok) mem[tail] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) tail <= tail + 1'b1;
         if (pop_ok)  head <= head + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

   // init keeps the last dequeued value visible
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else if (init) begin
         valid_out <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (pop_ok) data_out <= mem[head];
      end
   end

`ifdef QUEUE_OVF_FLAG_EN
   always_ff @(posedge clk) begin
      if (clear) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (push && full) ovf_err <= 1'b1;
         if (pop && empty) unf_err <= 1'b1;
      end
   end
`else
   always_comb begin
      ovf_err = 1'b0;
      unf_err = 1'b0;
   end
`endif

endmodule

// File: tb/tb_queue_fifo.sv
// Self-checking bench for queue_fifo (WIDTH=2, LENGTH=2): directed plan plus randomized traffic
// against a queue-based model; honours QUEUE_OVF_FLAG_EN when defined.
module tb_queue_fifo;

   localparam int WIDTH  = 2;
   localparam int LENGTH = 2;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1, push = 1'b0, pop = 1'b0, init = 1'b0;
   logic [WIDTH-1:0]  data_in = '0;
   logic [WIDTH-1:0]  data_out;
   logic              valid_out, full, empty, ovf_err, unf_err;
   logic [LENGTH:0]   count;

   queue_fifo #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .init(init),
      .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
      .count(count), .full(full), .empty(empty),
      .ovf_err(ovf_err), .unf_err(unf_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // reference model
   int m_q[$];
   int m_dout  = 0;
   bit m_valid = 0;
   bit m_ovf   = 0;
   bit m_unf   = 0;
`ifdef QUEUE_OVF_FLAG_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit i, input bit pu, input bit po, input int d);
      bit was_full, was_empty;
      if (r) begin
         m_q.delete(); m_dout = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
      end else if (i) begin
         m_q.delete(); m_valid = 0; m_ovf = 0; m_unf = 0;
      end else begin
         was_full  = (m_q.size() == DEPTH);
         was_empty = (m_q.size() == 0);
         m_valid   = po && !was_empty;
         if (m_valid) m_dout = m_q.pop_front();
         if (pu && !was_full) m_q.push_back(d);
         if (FLAGS && pu && was_full)  m_ovf = 1;
         if (FLAGS && po && was_empty) m_unf = 1;
      end
   endtask

   // one clock: drive inputs, let the edge happen, advance model, return at negedge
   task automatic cycle(input bit r, input bit i, input bit pu, input bit po, input int d);
      rst = r; init = i; push = pu; pop = po; data_in = WIDTH'(d);
      @(posedge clk);
      model_step(r, i, pu, po, d);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",     int'(count),    m_q.size());
         chk("empty",     int'(empty),    int'(m_q.size() == 0));
         chk("full",      int'(full),     int'(m_q.size() == DEPTH));
         chk("valid_out", int'(valid_out), int'(m_valid));
         chk("data_out",  int'(data_out), m_dout);
         chk("ovf_err",   int'(ovf_err),  int'(m_ovf));
         chk("unf_err",   int'(unf_err),  int'(m_unf));
      end
   end

   initial begin
      int vals[4];
      int held;
      @(negedge clk);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk_en = 1'b1;
      cycle(0, 0, 0, 0, 0);
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full",  int'(full), 0);
      chk("rst_dout",  int'(data_out), 0);
      chk("rst_valid", int'(valid_out), 0);

      // fill then drain in order
      vals = '{3, 1, 2, 0};
      foreach (vals[k]) cycle(0, 0, 1, 0, vals[k]);
      chk("fill_count", int'(count), 4);
      chk("fill_full",  int'(full), 1);
      foreach (vals[k]) begin
         cycle(0, 0, 0, 1, 0);
         chk("drain_dout",  int'(data_out), vals[k]);
         chk("drain_valid", int'(valid_out), 1);
      end
      cycle(0, 0, 0, 0, 0);
      chk("drain_empty", int'(empty), 1);
      chk("drain_valid_off", int'(valid_out), 0);

      // overflow attempts leave contents intact
      vals = '{2, 3, 0, 2};
      foreach (vals[k]) cycle(0, 0, 1, 0, vals[k]);
      cycle(0, 0, 1, 0, 1);
      cycle(0, 0, 1, 0, 1);
      chk("ovf_count", int'(count), 4);
      chk("ovf_flag",  int'(ovf_err), FLAGS ? 1 : 0);
      foreach (vals[k]) begin
         cycle(0, 0, 0, 1, 0);
         chk("ovf_drain", int'(data_out), vals[k]);
      end
      chk("ovf_sticky", int'(ovf_err), FLAGS ? 1 : 0);
      cycle(0, 1, 0, 0, 0);
      chk("ovf_init_clr", int'(ovf_err), 0);

      // wrap-around
      cycle(0, 0, 1, 0, 2); cycle(0, 0, 1, 0, 2);
      cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0);
      vals = '{1, 2, 3, 0};
      foreach (vals[k]) cycle(0, 0, 1, 0, vals[k]);
      chk("wrap_full", int'(full), 1);
      foreach (vals[k]) begin
         cycle(0, 0, 0, 1, 0);
         chk("wrap_dout", int'(data_out), vals[k]);
      end

      // simultaneous push/pop from count=2
      cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 2);
      vals = '{1, 2, 3, 0};
      for (int k = 0; k < 6; k++) begin
         cycle(0, 0, 1, 1, (k + 3) % 4);
         chk("pp_count", int'(count), 2);
         chk("pp_dout",  int'(data_out), (k + 1) % 4);
      end
      cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0);
      chk("pp_drained", int'(empty), 1);
      // from empty: push wins
      cycle(0, 0, 1, 1, 3);
      chk("ppe_count", int'(count), 1);
      chk("ppe_valid", int'(valid_out), 0);
      // from full: pop wins
      cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 2); cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 1, 1);
      chk("ppf_count", int'(count), 3);
      chk("ppf_dout",  int'(data_out), 3);

      // pop on empty, then init with entries stored
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
      held = int'(data_out);
      chk("uf_held_pre", held, 0);
      cycle(0, 0, 0, 1, 0);
      chk("uf_valid", int'(valid_out), 0);
      chk("uf_dout",  int'(data_out), held);
      chk("uf_flag",  int'(unf_err), FLAGS ? 1 : 0);
      cycle(0, 0, 1, 0, 1); cycle(0, 0, 1, 0, 2); cycle(0, 0, 1, 0, 3);
      cycle(0, 1, 0, 1, 0);
      chk("init_count", int'(count), 0);
      chk("init_empty", int'(empty), 1);
      chk("init_dout",  int'(data_out), held);
      chk("init_valid", int'(valid_out), 0);

      // randomized traffic with push-heavy / pop-heavy phases
      for (int n = 0; n < 3000; n++) begin
         int bias;
         bit r, i;
         bias = ((n / 50) % 2 == 0) ? 75 : 25;
         r = ($urandom_range(0, 299) == 0);
         i = ($urandom_range(0, 149) == 0);
         cycle(r, i, $urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
               int'($urandom_range(0, 3)));
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
